// File: rtl/clk_div_gen.sv
// Power-of-two clock divider with glitch-free channel select, alignment pulse and lock flag.
// Define CLKGEN_GATE_EN to make enable=0 clear the divider instead of freezing it.
module clk_div_gen #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] clk_div,
  output logic              clk_sel,
  output logic              sel_busy,
  output logic              sync_pulse,
  output logic              locked
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  localparam logic [NUM_CH-1:0] CntOne    = NUM_CH'(1);
  localparam logic [SEL_W:0]    NumChSel  = (SEL_W + 1)'(NUM_CH);

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [SEL_W-1:0]   tgt_q, tgt_d;
  logic               clk_sel_q, clk_sel_d;
  logic               sync_q, sync_d;
  logic               locked_q, locked_d;
  logic               align;
  logic               sel_legal;

  assign align     = enable && (cnt_q == '1);
  assign sel_legal = ({1'b0, sel} < NumChSel);

  always_comb begin
    cnt_d     = cnt_q;
    state_d   = state_q;
    cur_d     = cur_q;
    tgt_d     = tgt_q;
    sync_d    = 1'b0;
    locked_d  = locked_q;
    clk_sel_d = 1'b0;

    if (enable) begin
      cnt_d  = cnt_q + CntOne;
      sync_d = align;
      if (align) begin
        locked_d = 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (sel_legal && (sel != cur_q)) begin
            tgt_d   = sel;
            state_d = StPending;
          end
        end
        StPending: begin
          // Commit wins over a same-cycle request; that request is re-evaluated next cycle.
          if (align) begin
            cur_d   = tgt_q;
            state_d = StIdle;
          end else if (sel_legal) begin
            if (sel == cur_q) begin
              state_d = StIdle;
            end else begin
              tgt_d = sel;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end else begin
`ifdef CLKGEN_GATE_EN
      cnt_d    = '0;
      locked_d = 1'b0;
`endif
    end

    // Select from next-state values so clk_sel stays a flop copy of clk_div[cur_sel].
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cur_d == i[SEL_W-1:0]) begin
        clk_sel_d = cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cur_q     <= '0;
      tgt_q     <= '0;
      clk_sel_q <= 1'b0;
      sync_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      clk_sel_q <= clk_sel_d;
      sync_q    <= sync_d;
      locked_q  <= locked_d;
    end
  end

  assign clk_div    = cnt_q;
  assign clk_sel    = clk_sel_q;
  assign sel_busy   = (state_q == StPending);
  assign sync_pulse = sync_q;
  assign locked     = locked_q;

endmodule
